uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. Each completed frame (one-cycle done tick plus data word) is captured into a circular FIFO. The host drains words through a first-word-fall-through read port. Provides level, almost-full and a sticky overrun flag so software never silently loses bytes.

---
 rtl/uart_rx_fifo.sv | 77 +++++++
 tb/tb_uart_rx_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures each done-tick word, drains through a FWFT read port.
// Write-to-read latency 1 cycle; flags/level registered; a write while full without a pop is dropped and sets sticky overrun.
module uart_rx_fifo #(
    parameter int DBIT     = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              do_rd, do_wr, drop;

    assign empty       = (level_q == '0);
    assign full        = (level_q == DEPTH_L);
    assign almost_full = (level_q >= AF_L);
    assign level       = level_q;
    assign overrun     = overrun_q;
    assign r_data      = empty ? '0 : mem_q[rptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | rd);
    assign drop  = wr & full & ~rd;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (do_wr && !do_rd)      level_d = level_q + 1'b1;
        else if (do_rd && !do_wr) level_d = level_q - 1'b1;
        // Set wins over a simultaneous clear so a fresh drop is never lost.
        if (drop)         overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) mem_q[wptr_q] <= w_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations for reset, ordering, full/overrun and wrap behaviour.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset, wr, rd, ovr_clr;
    logic [7:0] w_data, r_data;
    logic       empty, full, almost_full, overrun;
    logic [4:0] level;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .almost_full (almost_full),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr = 1'b0; rd = 1'b0; ovr_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; w_data = d; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, r_data, exp);
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_rdata"}, r_data, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        int         mlvl, nw, nr, cyc;
        logic       mwr, mrd;

        idle();
        w_data = 8'h00;
        reset  = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_reset_state("rst");

        // Three words, then drain in order.
        push(8'h41);
        chk("w1_empty", empty, 0);
        chk("w1_rdata", r_data, 8'h41);
        chk("w1_level", level, 1);
        push(8'h42);
        push(8'h43);
        chk("w3_level", level, 3);
        pop_chk("p1_data", 8'h41);
        chk("p1_level", level, 2);
        pop_chk("p2_data", 8'h42);
        pop_chk("p3_data", 8'h43);
        chk("p3_level", level, 0);
        chk("p3_empty", empty, 1);
        chk("p3_rdata", r_data, 0);

        // Fill to full, drop one, drain exactly 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk($sformatf("fill_level%0d", i), level, i + 1);
            chk($sformatf("fill_af%0d", i), almost_full, (i + 1 >= 12) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        chk("fill_ovr0", overrun, 0);
        push(8'hAA);
        chk("drop_ovr", overrun, 1);
        chk("drop_level", level, 16);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i), 8'(i));
        chk("drain_empty", empty, 1);
        chk("drain_ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("clr_ovr", overrun, 0);

        // Full with simultaneous write and pop: no overrun, head advances.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("full2", full, 1);
        wr = 1'b1; rd = 1'b1; w_data = 8'h55;
        tick();
        idle();
        chk("wrrd_full_ovr", overrun, 0);
        chk("wrrd_full_level", level, 16);
        chk("wrrd_full_head", r_data, 8'h11);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("drain2_%0d", i), 8'(8'h10 + i));
        pop_chk("drain2_last", 8'h55);
        chk("drain2_empty", empty, 1);

        // Empty with simultaneous write and pop: only the write happens.
        wr = 1'b1; rd = 1'b1; w_data = 8'h66;
        tick();
        idle();
        chk("wrrd_empty_level", level, 1);
        chk("wrrd_empty_rdata", r_data, 8'h66);
        pop_chk("wrrd_empty_pop", 8'h66);

        // Interleaved traffic, 40 words, level capped at 5, pointers wrap twice.
        q.delete();
        mlvl = 0; nw = 0; nr = 0; cyc = 0;
        while (nr < 40 && cyc < 400) begin
            mwr = (nw < 40) && (mlvl < 5) && ((cyc % 4) != 3);
            mrd = (mlvl > 0) && ((cyc % 3) != 0 || mlvl == 5 || nw == 40);
            wr = mwr; rd = mrd; w_data = 8'(8'h80 + nw);
            if (mrd) chk($sformatf("wrap_data%0d", nr), r_data, q[0]);
            tick();
            if (mrd) begin void'(q.pop_front()); nr++; mlvl--; end
            if (mwr) begin q.push_back(8'(8'h80 + nw)); nw++; mlvl++; end
            chk($sformatf("wrap_level_c%0d", cyc), level, mlvl);
            cyc++;
        end
        idle();
        chk("wrap_done", nr, 40);
        chk("wrap_empty", empty, 1);

        // Mid-stream reset with level 7 and overrun set.
        for (int i = 0; i < 17; i++) push(8'(i));
        for (int i = 0; i < 9; i++) begin rd = 1'b1; tick(); end
        idle();
        chk("pre_rst_level", level, 7);
        chk("pre_rst_ovr", overrun, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("midrst");

        // Clear and drop in the same cycle: set wins.
        for (int i = 0; i < 16; i++) push(8'(i));
        wr = 1'b1; ovr_clr = 1'b1; w_data = 8'hEE;
        tick();
        idle();
        chk("clr_drop_ovr", overrun, 1);
        chk("clr_drop_level", level, 16);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("clr_after", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
